// File: rtl/bcd_seg_scan_driver.sv
// Two-digit multiplexed 7-segment driver for the score counter's BCD output.
// Scans units/tens with dead time, blanks a leading zero, shows a mode dot and blinks.
module bcd_seg_scan_driver #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEAD_CYCLES  = 500,
  parameter int BLINK_FRAMES = 100,
  parameter int SEG_ACT_LOW  = 1,
  parameter int AN_ACT_LOW   = 1,
  parameter int BLANK_LZ     = 1
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic [7:0] I_bcd,
  input  logic       I_dp_en,
  input  logic       I_blink,
  output logic [6:0] O_seg,
  output logic       O_dp,
  output logic [1:0] O_an
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [6:0]    SEG_OFF    = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic          DP_OFF     = (SEG_ACT_LOW != 0);
  localparam logic [1:0]    AN_OFF     = (AN_ACT_LOW != 0) ? 2'b11 : 2'b00;

  typedef enum logic {S_UNITS = 1'b0, S_TENS = 1'b1} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [BW-1:0] r_blinkCnt;
  logic          r_blinkPh;
  logic [7:0]    r_snapBcd;
  logic          r_snapDp;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic [1:0]    r_an;

  logic       w_frameStart;
  logic       w_slotEnd;
  logic       w_frameEnd;
  logic [7:0] w_bcd;
  logic       w_dpSnap;
  logic [3:0] w_nib;
  logic       w_dead;
  logic       w_blank;
  logic       w_visible;
  logic [6:0] w_segHi;
  logic [6:0] w_segOn;
  logic       w_dpOn;
  logic [1:0] w_anOn;

  // The frame-start cycle already uses the freshly captured value so the
  // whole frame is drawn from one coherent snapshot even with no dead time.
  always_comb begin
    w_frameStart = (r_state == S_UNITS) && (r_cnt == '0);
    w_slotEnd    = (r_cnt == CNT_LAST);
    w_frameEnd   = (r_state == S_TENS) && w_slotEnd;
    w_bcd        = w_frameStart ? I_bcd : r_snapBcd;
    w_dpSnap     = w_frameStart ? I_dp_en : r_snapDp;
    w_nib        = (r_state == S_TENS) ? w_bcd[7:4] : w_bcd[3:0];
    w_dead       = (32'(r_cnt) < DEAD_CYCLES);
    w_blank      = (BLANK_LZ != 0) && (r_state == S_TENS) && (w_bcd[7:4] == 4'd0);
    w_visible    = !w_dead && !w_blank && !(I_blink && r_blinkPh);
  end

  always_comb begin
    w_segHi = 7'h40;
    case (w_nib)
      4'd0: w_segHi = 7'h3F;
      4'd1: w_segHi = 7'h06;
      4'd2: w_segHi = 7'h5B;
      4'd3: w_segHi = 7'h4F;
      4'd4: w_segHi = 7'h66;
      4'd5: w_segHi = 7'h6D;
      4'd6: w_segHi = 7'h7D;
      4'd7: w_segHi = 7'h07;
      4'd8: w_segHi = 7'h7F;
      4'd9: w_segHi = 7'h6F;
      default: w_segHi = 7'h40;
    endcase
  end

  always_comb begin
    w_segOn = w_visible ? w_segHi : 7'h00;
    w_dpOn  = w_visible && (r_state == S_UNITS) && w_dpSnap;
    w_anOn  = 2'b00;
    if (w_visible) w_anOn = (r_state == S_TENS) ? 2'b10 : 2'b01;
  end

  // Polarity is applied by XOR with the off pattern just before the pins.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state    <= S_UNITS;
      r_cnt      <= '0;
      r_blinkCnt <= '0;
      r_blinkPh  <= 1'b0;
      r_snapBcd  <= 8'h00;
      r_snapDp   <= 1'b0;
      r_seg      <= SEG_OFF;
      r_dp       <= DP_OFF;
      r_an       <= AN_OFF;
    end else begin
      r_cnt <= w_slotEnd ? '0 : r_cnt + CW'(1);
      if (w_slotEnd) r_state <= (r_state == S_UNITS) ? S_TENS : S_UNITS;
      if (w_frameStart) begin
        r_snapBcd <= I_bcd;
        r_snapDp  <= I_dp_en;
      end
      if (w_frameEnd) begin
        if (r_blinkCnt == BLINK_LAST) begin
          r_blinkCnt <= '0;
          r_blinkPh  <= ~r_blinkPh;
        end else begin
          r_blinkCnt <= r_blinkCnt + BW'(1);
        end
      end
      r_seg <= w_segOn ^ SEG_OFF;
      r_dp  <= w_dpOn ^ DP_OFF;
      r_an  <= w_anOn ^ AN_OFF;
    end
  end

  assign O_seg = r_seg;
  assign O_dp  = r_dp;
  assign O_an  = r_an;

endmodule
